// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Package : video_pkg
// Purpose : Shared pixel type, capture FSM states and address-width helper.
// Rev     : 1.0  initial release
// ============================================================================
package video_pkg;

  typedef logic [11:0] pixel_t;

  typedef enum logic [1:0] {
    S_WAIT_VS_ON  = 2'd0,
    S_WAIT_VS_OFF = 2'd1,
    S_ACTIVE      = 2'd2
  } cap_state_e;

  function automatic int addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgb444_byte_packer.sv
`default_nettype none
// ============================================================================
// Module  : rgb444_byte_packer
// Purpose : Byte-phase tracking and RGB444 assembly from DVP byte pairs.
// Rev     : 1.0  initial release
// ============================================================================
module rgb444_byte_packer
  import video_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       href_i,
  input  logic       href_rise_i,
  input  logic       href_fall_i,
  input  logic [7:0] data_i,
  output pixel_t     pix_o,
  output logic       pix_valid_o,
  output logic       odd_byte_o
);

  logic       phase_q, phase_d;
  logic [3:0] red_q, red_d;
  pixel_t     pix_q, pix_d;
  logic       valid_q, valid_d;
  logic       w_phase;

  // A new line always starts on the red byte, whatever the previous line left.
  assign w_phase = href_rise_i ? 1'b0 : phase_q;

  always_comb begin
    phase_d = phase_q;
    red_d   = red_q;
    pix_d   = pix_q;
    valid_d = 1'b0;
    if (clear_i) begin
      phase_d = 1'b0;
      red_d   = '0;
    end else if (en_i && href_i) begin
      phase_d = ~w_phase;
      if (!w_phase) begin
        red_d = data_i[3:0];
      end else begin
        pix_d   = {red_q, data_i};
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      red_q   <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      red_q   <= red_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
    end
  end

  assign pix_o       = pix_q;
  assign pix_valid_o = valid_q;
  assign odd_byte_o  = href_fall_i && phase_q;

endmodule
`default_nettype wire

// File: rtl/ov7670_frame_writer.sv
`default_nettype none
// ============================================================================
// Module  : ov7670_frame_writer
// Purpose : OV7670 DVP capture into a linear RGB444 frame buffer with frame
//           integrity reporting. Optional statistics: OV7670_FRAME_STATS_EN.
// Rev     : 1.0  initial release
// ============================================================================
module ov7670_frame_writer
  import video_pkg::*;
#(
  parameter  int RESOLUTION_WIDTH  = 640,
  parameter  int RESOLUTION_HEIGHT = 480,
  parameter  int VSYNC_POL         = 1,
  localparam int AW = addr_w(RESOLUTION_WIDTH, RESOLUTION_HEIGHT),
  localparam int XW = $clog2(RESOLUTION_WIDTH),
  localparam int YW = $clog2(RESOLUTION_HEIGHT)
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_data,
  output logic          w_clk,
  output logic          w_en,
  output logic [AW-1:0] w_addr,
  output logic [11:0]   w_data,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          frame_done,
  output logic          frame_err,
  output logic [15:0]   stat_lines,
  output logic [19:0]   stat_pixels
);

  localparam int            LW          = $clog2(RESOLUTION_WIDTH + 1);
  localparam logic [AW-1:0] c_last_addr = AW'(RESOLUTION_WIDTH * RESOLUTION_HEIGHT - 1);
  localparam logic [XW-1:0] c_x_max     = XW'(RESOLUTION_WIDTH - 1);
  localparam logic [YW-1:0] c_y_max     = YW'(RESOLUTION_HEIGHT - 1);
  localparam logic [LW-1:0] c_line_max  = LW'(RESOLUTION_WIDTH);
  localparam logic          c_vs_on     = (VSYNC_POL != 0);

  logic       vs_q, href_q, href_prev_q;
  logic [7:0] data_q;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vs_q        <= 1'b0;
      href_q      <= 1'b0;
      href_prev_q <= 1'b0;
      data_q      <= '0;
    end else begin
      vs_q        <= cam_vsync;
      href_q      <= cam_href;
      href_prev_q <= href_q;
      data_q      <= cam_data;
    end
  end

  cap_state_e state_q, state_d;
  logic       w_vs_act, w_active, w_capture, w_enter, w_frame_done;
  logic       w_href_rise, w_href_fall;

  assign w_vs_act     = (vs_q == c_vs_on);
  assign w_active     = (state_q == S_ACTIVE);
  assign w_capture    = w_active && !w_vs_act;
  assign w_frame_done = w_active && w_vs_act;
  assign w_enter      = (state_q == S_WAIT_VS_OFF) && !w_vs_act;
  assign w_href_rise  = href_q && !href_prev_q;
  assign w_href_fall  = !href_q && href_prev_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT_VS_ON:  if (w_vs_act)  state_d = S_WAIT_VS_OFF;
      S_WAIT_VS_OFF: if (!w_vs_act) state_d = S_ACTIVE;
      S_ACTIVE:      if (w_vs_act)  state_d = S_WAIT_VS_OFF;
      default:       state_d = S_WAIT_VS_ON;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state_q <= S_WAIT_VS_ON;
    else     state_q <= state_d;
  end

  pixel_t w_pix;
  logic   w_pix_valid, w_odd_raw;

  rgb444_byte_packer u_packer (
    .clk         (pclk),
    .rst         (rst),
    .clear_i     (w_enter),
    .en_i        (w_capture),
    .href_i      (href_q),
    .href_rise_i (w_href_rise),
    .href_fall_i (w_href_fall),
    .data_i      (data_q),
    .pix_o       (w_pix),
    .pix_valid_o (w_pix_valid),
    .odd_byte_o  (w_odd_raw)
  );

  logic [AW-1:0] addr_q, addr_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [LW-1:0] line_pix_q, line_pix_d;
  logic          full_q, full_d;
  logic          err_acc_q, err_acc_d;
  logic          frame_err_q, frame_err_d;
  logic          w_wr, w_last_wr, w_err_now, w_short;

  // full_q marks that the last address has been written; the address is
  // parked there so it never wraps back over the start of the frame.
  assign w_wr      = w_pix_valid && !full_q;
  assign w_last_wr = w_wr && (addr_q == c_last_addr);
  assign w_short   = !(full_q || w_last_wr);
  assign w_err_now = err_acc_q
                   | (w_active && w_odd_raw)
                   | (w_pix_valid && (line_pix_q == c_line_max))
                   | (w_pix_valid && full_q)
                   | (w_frame_done && href_q);

  always_comb begin
    addr_d      = addr_q;
    x_d         = x_q;
    y_d         = y_q;
    line_pix_d  = line_pix_q;
    full_d      = full_q;
    err_acc_d   = err_acc_q;
    frame_err_d = frame_err_q;
    if (w_enter) begin
      addr_d     = '0;
      x_d        = '0;
      y_d        = '0;
      line_pix_d = '0;
      full_d     = 1'b0;
      err_acc_d  = 1'b0;
    end else if (w_active) begin
      if (w_wr) begin
        if (addr_q == c_last_addr) full_d = 1'b1;
        else                       addr_d = addr_q + 1'b1;
      end
      // A write coinciding with href falling still uses the old x/y.
      if (w_href_fall) begin
        x_d        = '0;
        line_pix_d = '0;
        if (y_q != c_y_max) y_d = y_q + 1'b1;
      end else begin
        if (w_wr && (x_q != c_x_max)) x_d = x_q + 1'b1;
        if (w_pix_valid && (line_pix_q != c_line_max)) line_pix_d = line_pix_q + 1'b1;
      end
      err_acc_d = w_err_now;
    end
    if (w_frame_done) frame_err_d = w_err_now | w_short;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      line_pix_q  <= '0;
      full_q      <= 1'b0;
      err_acc_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      line_pix_q  <= line_pix_d;
      full_q      <= full_d;
      err_acc_q   <= err_acc_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef OV7670_FRAME_STATS_EN
  logic [15:0] line_cnt_q, line_cnt_d, stat_lines_q, stat_lines_d;
  logic [19:0] pix_cnt_q, pix_cnt_d, stat_pix_q, stat_pix_d;

  always_comb begin
    line_cnt_d   = line_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    stat_lines_d = stat_lines_q;
    stat_pix_d   = stat_pix_q;
    if (w_enter) begin
      line_cnt_d = '0;
      pix_cnt_d  = '0;
    end else if (w_active) begin
      if (w_capture && w_href_rise && (line_cnt_q != '1)) line_cnt_d = line_cnt_q + 1'b1;
      if (w_wr && (pix_cnt_q != '1))                      pix_cnt_d  = pix_cnt_q + 1'b1;
    end
    if (w_frame_done) begin
      stat_lines_d = line_cnt_d;
      stat_pix_d   = pix_cnt_d;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      line_cnt_q   <= '0;
      pix_cnt_q    <= '0;
      stat_lines_q <= '0;
      stat_pix_q   <= '0;
    end else begin
      line_cnt_q   <= line_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      stat_lines_q <= stat_lines_d;
      stat_pix_q   <= stat_pix_d;
    end
  end

  assign stat_lines  = stat_lines_q;
  assign stat_pixels = stat_pix_q;
`else
  assign stat_lines  = '0;
  assign stat_pixels = '0;
`endif

  assign w_clk      = pclk;
  assign w_en       = w_wr;
  assign w_addr     = addr_q;
  assign w_data     = w_pix;
  assign pixel_x    = x_q;
  assign pixel_y    = y_q;
  assign frame_done = w_frame_done;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire
